// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- multi-cycle radix-2 restoring divider (EX-stage divide responder)
//
// The EX stage raises start_i with the operands and stalls until ready_o is high.
// One quotient bit is produced per clock, so a normal divide takes WIDTH cycles.
// A zero divisor takes a one-cycle path.
//
// Build option:
//   DIV_BYZERO_FLAG_EN  when defined, adds the byzero_o port. That port flags a
//                       zero divisor alongside ready_o. Timing and results are
//                       the same in both builds.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request; held high by EX until ready_o is seen
//   annul_i       abort the operation in flight (pipeline flush)
//   result_o      {remainder, quotient}
//   ready_o       result valid; held while start_i stays high
//   byzero_o      divisor was zero (only with DIV_BYZERO_FLAG_EN)
// -----------------------------------------------------------------------------
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
`ifdef DIV_BYZERO_FLAG_EN
  ,
  output logic               byzero_o
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_BY_ZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_e;

  // Two's-complement negation.
  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude: negate only for a signed divide with a negative operand.
  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) begin
      return neg_f(x);
    end else begin
      return x;
    end
  endfunction

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   div_q,    div_d;
  logic               signed_q, signed_d;
  logic               s1_q,     s1_d;
  logic               s2_q,     s2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q,  ready_d;
`ifdef DIV_BYZERO_FLAG_EN
  logic               byzero_q, byzero_d;
`endif

  // Datapath for one restoring step.
  // The shifted partial remainder is WIDTH+1 bits wide. Its top bit is the bit
  // shifted out of the accumulator. When the step fits, the new remainder is
  // below div_q, so WIDTH bits are enough to hold it.
  logic [WIDTH:0]     rem_ext_s;
  logic [WIDTH-1:0]   diff_s;
  logic               fits_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [WIDTH-1:0]   quot_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  // One iteration of the restoring divide, plus the final sign correction.
  always_comb begin
    rem_ext_s = acc_q[2*WIDTH-1:WIDTH-1];
    fits_s    = (rem_ext_s >= {1'b0, div_q});
    diff_s    = rem_ext_s[WIDTH-1:0] - div_q;
    if (fits_s) begin
      acc_step_s = {diff_s, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step_s = {acc_q[2*WIDTH-2:0], 1'b0};
    end
    // The quotient is negative when the operand signs differ.
    // The remainder always takes the sign of the dividend.
    if (signed_q && (s1_q != s2_q)) begin
      quot_fix_s = neg_f(acc_step_s[WIDTH-1:0]);
    end else begin
      quot_fix_s = acc_step_s[WIDTH-1:0];
    end
    if (signed_q && s1_q) begin
      rem_fix_s = neg_f(acc_step_s[2*WIDTH-1:WIDTH]);
    end else begin
      rem_fix_s = acc_step_s[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state and next-output logic of the divide handshake FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    div_d    = div_q;
    signed_d = signed_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
    byzero_d = byzero_q;
`endif
    case (state_q)
      ST_FREE: begin
        if (start_i && !annul_i) begin
          signed_d = signed_div_i;
          s1_d     = opdata1_i[WIDTH-1];
          s2_d     = opdata2_i[WIDTH-1];
          cnt_d    = {CNT_W{1'b0}};
          acc_d    = {{WIDTH{1'b0}}, abs_f(opdata1_i, signed_div_i)};
          div_d    = abs_f(opdata2_i, signed_div_i);
          if (opdata2_i == {WIDTH{1'b0}}) begin
            state_d = ST_BY_ZERO;
          end else begin
            state_d = ST_ON;
          end
        end else begin
          state_d = ST_FREE;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          acc_d = acc_step_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = ST_END;
            result_d = {rem_fix_s, quot_fix_s};
            ready_d  = 1'b1;
          end else begin
            state_d = ST_ON;
          end
        end
      end
      ST_BY_ZERO: begin
        // A flush still wins over the zero-divisor report.
        if (annul_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          state_d  = ST_END;
          result_d = {(2*WIDTH){1'b0}};
          ready_d  = 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
          byzero_d = 1'b1;
`endif
        end
      end
      ST_END: begin
        // EX holds start_i until it has consumed the result. annul_i is ignored here.
        if (start_i) begin
          state_d = ST_END;
        end else begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
`ifdef DIV_BYZERO_FLAG_EN
          byzero_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d  = ST_FREE;
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
`ifdef DIV_BYZERO_FLAG_EN
        byzero_d = 1'b0;
`endif
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FREE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      div_q    <= {WIDTH{1'b0}};
      signed_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
      ready_q  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
      byzero_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      div_q    <= div_d;
      signed_q <= signed_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_BYZERO_FLAG_EN
      byzero_q <= byzero_d;
`endif
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
  assign byzero_o = byzero_q;
`endif

endmodule
